hazard_ctrl: RTL and testbench

Pipeline hazard and flow controller for the 5-stage MIPS pipeline. It drives the PC load enable, the IF/ID register's `ld` and `flush` inputs, and the ID/EX bubble select. It sequences stalls for load-use hazards, branch-operand hazards and instruction-memory wait states, and it squashes the wrong-path fetch on taken branches and jumps. It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Signal bundle between the pipeline datapath and the hazard/flow controller.
// master = datapath side (drives ID/EX hazard info), slave = hazard_ctrl.
interface hazard_if #(
  parameter int CNT_W = 16
);
  // imem_ready is a one-way ready: when low the fetched word is not valid and
  // nothing may advance past IF; there is no matching valid from this block.
  logic             imem_ready;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             id_uses_rt;
  logic             id_branch;
  logic             branch_taken;
  logic             jump;
  logic             idex_mem_read;
  logic             idex_reg_write;
  logic [4:0]       idex_rd;
  logic             pc_ld;
  logic             ifid_ld;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output imem_ready, ifid_rs, ifid_rt, id_uses_rt, id_branch, branch_taken,
           jump, idex_mem_read, idex_reg_write, idex_rd,
    input  pc_ld, ifid_ld, ifid_flush, idex_bubble, stall_cycles, flush_count
  );

  modport slave (
    input  imem_ready, ifid_rs, ifid_rt, id_uses_rt, id_branch, branch_taken,
           jump, idex_mem_read, idex_reg_write, idex_rd,
    output pc_ld, ifid_ld, ifid_flush, idex_bubble, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage MIPS pipeline, with saturating
// stall-cycle and flush-pulse counters for performance debug.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  bus,
  output logic     state_dbg
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic match;
  logic load_use;
  logic br_alu;
  logic br_load;
  logic redirect;

  logic pc_ld_c, ifid_ld_c, flush_c, bubble_c;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Register 0 is hard-wired zero, so it can never be a real producer.
  assign match = (bus.idex_rd != 5'd0) &&
                 ((bus.idex_rd == bus.ifid_rs) ||
                  (bus.id_uses_rt && (bus.idex_rd == bus.ifid_rt)));

  assign load_use = bus.idex_mem_read & match;
  assign br_alu   = bus.id_branch & bus.idex_reg_write & ~bus.idex_mem_read & match;
  assign br_load  = bus.id_branch & load_use;
  assign redirect = (bus.branch_taken & bus.id_branch) | bus.jump;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_ld_c   = 1'b1;
    ifid_ld_c = 1'b1;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;
    if (!rst) begin
      case (state)
        HOLD: begin
          pc_ld_c   = 1'b0;
          ifid_ld_c = 1'b0;
          bubble_c  = 1'b1;
          state_nxt = RUN;
        end
        default: begin
          if (!bus.imem_ready) begin
            pc_ld_c   = 1'b0;
            ifid_ld_c = 1'b0;
            bubble_c  = 1'b1;
          end else if (load_use || br_alu) begin
            pc_ld_c   = 1'b0;
            ifid_ld_c = 1'b0;
            bubble_c  = 1'b1;
            // The loaded value reaches the ID comparator one cycle later than
            // an ALU result, so a branch on a load needs an extra stall.
            if (br_load) begin
              state_nxt = HOLD;
            end
          end else if (redirect) begin
            flush_c = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_ld_c && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush_c && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign bus.pc_ld        = pc_ld_c;
  assign bus.ifid_ld      = ifid_ld_c;
  assign bus.ifid_flush   = flush_c;
  assign bus.idex_bubble  = bubble_c;
  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_count  = flush_cnt;
  assign state_dbg        = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: a 16-bit-counter instance for the
// functional scenarios and a 4-bit-counter instance for saturation.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  logic st16;
  logic st4;

  int total;
  int bad;

  hazard_if #(.CNT_W(16)) hif ();
  hazard_if #(.CNT_W(4))  hif4 ();

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (hif.slave),
    .state_dbg (st16)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .bus       (hif4.slave),
    .state_dbg (st4)
  );

  // The narrow-counter instance mirrors the same stimulus.
  assign hif4.imem_ready     = hif.imem_ready;
  assign hif4.ifid_rs        = hif.ifid_rs;
  assign hif4.ifid_rt        = hif.ifid_rt;
  assign hif4.id_uses_rt     = hif.id_uses_rt;
  assign hif4.id_branch      = hif.id_branch;
  assign hif4.branch_taken   = hif.branch_taken;
  assign hif4.jump           = hif.jump;
  assign hif4.idex_mem_read  = hif.idex_mem_read;
  assign hif4.idex_reg_write = hif.idex_reg_write;
  assign hif4.idex_rd        = hif.idex_rd;

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    hif.imem_ready     = 1'b1;
    hif.ifid_rs        = 5'd0;
    hif.ifid_rt        = 5'd0;
    hif.id_uses_rt     = 1'b0;
    hif.id_branch      = 1'b0;
    hif.branch_taken   = 1'b0;
    hif.jump           = 1'b0;
    hif.idex_mem_read  = 1'b0;
    hif.idex_reg_write = 1'b0;
    hif.idex_rd        = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic pc, input logic ld,
                            input logic fl, input logic bb);
    check({tag, ".outs"}, {28'd0, hif.pc_ld, hif.ifid_ld, hif.ifid_flush, hif.idex_bubble},
          {28'd0, pc, ld, fl, bb});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;

    // reset while in HOLD
    hif.id_branch     = 1'b1;
    hif.idex_mem_read = 1'b1;
    hif.idex_rd       = 5'd9;
    hif.ifid_rt       = 5'd9;
    hif.id_uses_rt    = 1'b1;
    settle();
    check_outs("rst_pre", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("rst_hold_state", {31'd0, st16}, 32'd1);
    rst = 1'b1;
    settle();
    check_outs("rst_forced", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    settle();
    check_outs("rst_forced2", 1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_state", {31'd0, st16}, 32'd0);
    step();
    rst = 1'b0;
    idle();
    settle();
    check("rst_stall_cnt", {16'd0, hif.stall_cycles}, 32'd0);
    check("rst_flush_cnt", {16'd0, hif.flush_count}, 32'd0);
    check("post_rst_state", {31'd0, st16}, 32'd0);
    check_outs("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);

    // load-use on rs
    do_reset();
    hif.idex_mem_read = 1'b1;
    hif.idex_rd       = 5'd8;
    hif.ifid_rs       = 5'd8;
    settle();
    check_outs("lu_stall", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    hif.ifid_rs = 5'd8;
    settle();
    check_outs("lu_after", 1'b1, 1'b1, 1'b0, 1'b0);
    check("lu_cnt", {16'd0, hif.stall_cycles}, 32'd1);
    step();
    // $zero destination never hazards
    hif.idex_mem_read = 1'b1;
    hif.idex_rd       = 5'd0;
    hif.ifid_rs       = 5'd0;
    settle();
    check_outs("lu_r0", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    // rt only counts when actually read
    hif.idex_rd    = 5'd7;
    hif.ifid_rs    = 5'd3;
    hif.ifid_rt    = 5'd7;
    hif.id_uses_rt = 1'b0;
    settle();
    check_outs("lu_rt_unused", 1'b1, 1'b1, 1'b0, 1'b0);
    hif.id_uses_rt = 1'b1;
    settle();
    check_outs("lu_rt_used", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    settle();
    check("lu_cnt2", {16'd0, hif.stall_cycles}, 32'd2);

    // branch on load: RUN stall, HOLD stall, then RUN
    do_reset();
    hif.id_branch     = 1'b1;
    hif.idex_mem_read = 1'b1;
    hif.idex_rd       = 5'd9;
    hif.ifid_rt       = 5'd9;
    hif.id_uses_rt    = 1'b1;
    settle();
    check_outs("bl_c1", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    hif.idex_mem_read = 1'b0;
    hif.idex_rd       = 5'd0;
    hif.branch_taken  = 1'b1;
    hif.imem_ready    = 1'b0;
    settle();
    check("bl_hold_state", {31'd0, st16}, 32'd1);
    check_outs("bl_c2", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    hif.imem_ready   = 1'b1;
    hif.branch_taken = 1'b0;
    settle();
    check("bl_run_state", {31'd0, st16}, 32'd0);
    check_outs("bl_c3", 1'b1, 1'b1, 1'b0, 1'b0);
    check("bl_cnt", {16'd0, hif.stall_cycles}, 32'd2);

    // branch on ALU result, taken once resolved
    do_reset();
    hif.id_branch      = 1'b1;
    hif.branch_taken   = 1'b1;
    hif.idex_reg_write = 1'b1;
    hif.idex_rd        = 5'd5;
    hif.ifid_rs        = 5'd5;
    settle();
    check_outs("ba_stall", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    hif.idex_reg_write = 1'b0;
    hif.idex_rd        = 5'd0;
    settle();
    check_outs("ba_flush", 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    settle();
    check("ba_flush_cnt", {16'd0, hif.flush_count}, 32'd1);
    check("ba_stall_cnt", {16'd0, hif.stall_cycles}, 32'd1);
    check_outs("ba_after", 1'b1, 1'b1, 1'b0, 1'b0);

    // jump waiting on instruction memory
    do_reset();
    hif.jump       = 1'b1;
    hif.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_outs($sformatf("jw_wait%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    hif.imem_ready = 1'b1;
    settle();
    check_outs("jw_flush", 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    settle();
    check_outs("jw_after", 1'b1, 1'b1, 1'b0, 1'b0);
    check("jw_stall_cnt", {16'd0, hif.stall_cycles}, 32'd3);
    check("jw_flush_cnt", {16'd0, hif.flush_count}, 32'd1);

    // saturation on the 4-bit counter
    do_reset();
    hif.imem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
    end
    settle();
    check("sat4_cnt", {28'd0, hif4.stall_cycles}, 32'd15);
    check("sat16_cnt", {16'd0, hif.stall_cycles}, 32'd20);
    step();
    settle();
    check("sat4_hold", {28'd0, hif4.stall_cycles}, 32'd15);
    check("sat4_flush", {28'd0, hif4.flush_count}, 32'd0);
    idle();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
